// File: rtl/dp_selftest_seq.sv
// Self-test sequencer for the single-cycle RV64I datapath: replays a stored program
// segment by segment and checks PC and register writeback against expected values.
module dp_selftest_seq #(
  parameter int unsigned  XLEN  = 64,
  parameter int unsigned  DEPTH = 16,
  parameter logic [31:0]  NOP   = 32'h00000013,
  localparam int unsigned IW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [31:0]     load_instr,
  input  logic            load_seg,
  input  logic            load_chk,
  input  logic [4:0]      load_rd,
  input  logic [XLEN-1:0] load_exp,
  input  logic            clear,
  input  logic            start,
  output logic [31:0]     instruction,
  output logic            dp_rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   fail_count,
  output logic [IW-1:0]   fail_idx
);

  typedef enum logic [1:0] {StIdle, StRst, StIssue, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   pc_ref_q, pc_ref_d;
  logic [CW-1:0]     fail_count_q, fail_count_d;
  logic [IW-1:0]     fail_idx_q, fail_idx_d;

  logic [31:0]       instr_mem [DEPTH];
  logic              seg_mem   [DEPTH];
  logic              chk_mem   [DEPTH];
  logic [4:0]        rd_mem    [DEPTH];
  logic [XLEN-1:0]   exp_mem   [DEPTH];

  logic              load_we;
  logic              last_entry;
  logic              fail_e;
  logic [IW-1:0]     idx_nxt;

  assign load_ready = (state_q == StIdle) && (wr_cnt_q < CW'(DEPTH));
  assign load_we    = load_valid && load_ready;
  assign idx_nxt    = idx_q + 1'b1;
  assign last_entry = (CW'(idx_q) == wr_cnt_q - 1'b1);

  assign fail_e = (pc_in != pc_ref_q) ||
                  (chk_mem[idx_q] && (!wb_en || (wb_rd != rd_mem[idx_q]) ||
                                      (wb_data != exp_mem[idx_q])));

  assign dp_rst      = rst || (state_q == StRst);
  assign busy        = (state_q == StRst) || (state_q == StIssue);
  assign done        = (state_q == StDone);
  assign pass        = done && (fail_count_q == '0);
  assign fail_count  = fail_count_q;
  assign fail_idx    = fail_idx_q;
  assign instruction = (state_q == StIssue) ? instr_mem[idx_q] : NOP;

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    idx_d        = idx_q;
    pc_ref_d     = pc_ref_q;
    fail_count_d = fail_count_q;
    fail_idx_d   = fail_idx_q;
    if (load_we) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (clear) begin
          wr_cnt_d     = '0;
          fail_count_d = '0;
          state_d      = StIdle;
        end else if (start) begin
          fail_count_d = '0;
          // A load accepted alongside start is part of this run.
          if (wr_cnt_d == '0) begin
            state_d = StDone;
          end else begin
            idx_d      = '0;
            fail_idx_d = '0;
            state_d    = StRst;
          end
        end
      end
      StRst: begin
        pc_ref_d = '0;
        state_d  = StIssue;
      end
      StIssue: begin
        if (fail_e) begin
          fail_count_d = fail_count_q + 1'b1;
          if (fail_count_q == '0) begin
            fail_idx_d = idx_q;
          end
        end
        pc_ref_d = pc_ref_q + XLEN'(4);
        if (last_entry) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_nxt;
          state_d = seg_mem[idx_nxt] ? StRst : StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_cnt_q     <= '0;
      idx_q        <= '0;
      pc_ref_q     <= '0;
      fail_count_q <= '0;
      fail_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      idx_q        <= idx_d;
      pc_ref_q     <= pc_ref_d;
      fail_count_q <= fail_count_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  // Program storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      instr_mem[wr_cnt_q[IW-1:0]] <= load_instr;
      seg_mem[wr_cnt_q[IW-1:0]]   <= load_seg;
      chk_mem[wr_cnt_q[IW-1:0]]   <= load_chk;
      rd_mem[wr_cnt_q[IW-1:0]]    <= load_rd;
      exp_mem[wr_cnt_q[IW-1:0]]   <= load_exp;
    end
  end

endmodule

// File: tb/tb_dp_selftest_seq.sv
// Directed bench for dp_selftest_seq with a tiny ADDI/ADD datapath model.
module tb_dp_selftest_seq;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_valid, load_ready, load_seg, load_chk;
  logic [31:0]     load_instr;
  logic [4:0]      load_rd;
  logic [XLEN-1:0] load_exp;
  logic            clear, start;
  logic [31:0]     instruction;
  logic            dp_rst;
  logic [XLEN-1:0] pc_in;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            busy, done, pass;
  logic [CW-1:0]   fail_count;
  logic [IW-1:0]   fail_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dp_selftest_seq #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_instr(load_instr),
    .load_seg(load_seg), .load_chk(load_chk), .load_rd(load_rd), .load_exp(load_exp),
    .clear(clear), .start(start),
    .instruction(instruction), .dp_rst(dp_rst), .pc_in(pc_in),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_idx(fail_idx)
  );

  // Datapath model: PC counter plus register file, reset by dp_rst.
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] pc_m;
  logic            stuck_pc = 1'b0;
  logic [XLEN-1:0] imm, rs1v, rs2v;

  always @(posedge clk or posedge dp_rst) begin
    if (dp_rst) begin
      pc_m <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc_m <= pc_m + 64'd4;
      if (wb_en && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_rd   = instruction[11:7];
    wb_data = '0;
    imm     = {{52{instruction[31]}}, instruction[31:20]};
    rs1v    = regs[instruction[19:15]];
    rs2v    = regs[instruction[24:20]];
    if (instruction[6:0] == 7'h13 && instruction[14:12] == 3'd0) begin
      wb_en   = 1'b1;
      wb_data = rs1v + imm;
    end else if (instruction[6:0] == 7'h33) begin
      wb_en   = 1'b1;
      wb_data = rs1v + rs2v;
    end
  end

  assign pc_in = stuck_pc ? '0 : pc_m;

  logic [31:0]     log_instr [64];
  logic [XLEN-1:0] log_pc    [64];
  int              n_log;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_entry(input logic seg, input logic [31:0] ins, input logic chk,
                            input logic [4:0] rd, input logic [XLEN-1:0] ex);
    load_valid = 1'b1; load_seg = seg; load_instr = ins;
    load_chk = chk; load_rd = rd; load_exp = ex;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Pulse start, then count busy cycles and dp_rst cycles until done.
  task automatic run_prog(output int cycles, output int rst_cycles);
    int guard;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0; rst_cycles = 0; n_log = 0; guard = 0;
    while (!done && guard < 200) begin
      if (busy) begin
        cycles++;
        if (dp_rst) rst_cycles++;
        if (n_log < 64) begin
          log_instr[n_log] = instruction;
          log_pc[n_log]    = pc_in;
          n_log++;
        end
      end
      guard++;
      @(negedge clk);
    end
    if (!done) check("run_timeout", 64'd0, 64'd1);
  endtask

  int cyc, rcyc, acc;

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_seg = 1'b0; load_chk = 1'b0;
    load_instr = '0; load_rd = '0; load_exp = '0; clear = 1'b0; start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_instr", 64'(instruction), 64'(NOP));
    check("rst_dp_rst", 64'(dp_rst), 64'd1);
    check("rst_fail_count", 64'(fail_count), 64'd0);
    check("rst_fail_idx", 64'(fail_idx), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(load_ready), 64'd1);
    check("idle_dp_rst", 64'(dp_rst), 64'd0);

    // Single checked entry.
    load_entry(1'b1, 32'h00C00293, 1'b1, 5'd5, 64'd12);
    run_prog(cyc, rcyc);
    check("t1_cycles", 64'(cyc), 64'd2);
    check("t1_rst_cycles", 64'(rcyc), 64'd1);
    check("t1_pc", log_pc[1], 64'd0);
    check("t1_done", 64'(done), 64'd1);
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_fail_count", 64'(fail_count), 64'd0);

    // Three-entry program with ADD check.
    do_clear();
    load_entry(1'b1, 32'h00500093, 1'b0, 5'd0, 64'd0);
    load_entry(1'b0, 32'h00600113, 1'b0, 5'd0, 64'd0);
    load_entry(1'b0, 32'h002081B3, 1'b1, 5'd3, 64'd11);
    run_prog(cyc, rcyc);
    check("t2_cycles", 64'(cyc), 64'd4);
    check("t2_i0", 64'(log_instr[0]), 64'(NOP));
    check("t2_i1", 64'(log_instr[1]), 64'h00500093);
    check("t2_i2", 64'(log_instr[2]), 64'h00600113);
    check("t2_i3", 64'(log_instr[3]), 64'h002081B3);
    check("t2_pc2", log_pc[2], 64'd4);
    check("t2_pc3", log_pc[3], 64'd8);
    check("t2_pass", 64'(pass), 64'd1);

    // Wrong expectation on entry 2, then rerun.
    do_clear();
    load_entry(1'b1, 32'h00500093, 1'b0, 5'd0, 64'd0);
    load_entry(1'b0, 32'h00600113, 1'b0, 5'd0, 64'd0);
    load_entry(1'b0, 32'h002081B3, 1'b1, 5'd3, 64'd13);
    run_prog(cyc, rcyc);
    check("t3_fail_count", 64'(fail_count), 64'd1);
    check("t3_fail_idx", 64'(fail_idx), 64'd2);
    check("t3_pass", 64'(pass), 64'd0);
    run_prog(cyc, rcyc);
    check("t3r_cycles", 64'(cyc), 64'd4);
    check("t3r_fail_count", 64'(fail_count), 64'd1);
    check("t3r_fail_idx", 64'(fail_idx), 64'd2);
    check("t3r_pass", 64'(pass), 64'd0);

    // Two segments.
    do_clear();
    load_entry(1'b1, 32'h00F00313, 1'b0, 5'd0, 64'd0);
    load_entry(1'b0, 32'h00500393, 1'b0, 5'd0, 64'd0);
    load_entry(1'b1, 32'h0F000A13, 1'b0, 5'd0, 64'd0);
    load_entry(1'b0, 32'h05500A93, 1'b0, 5'd0, 64'd0);
    run_prog(cyc, rcyc);
    check("t4_cycles", 64'(cyc), 64'd6);
    check("t4_rst_cycles", 64'(rcyc), 64'd2);
    check("t4_i3", 64'(log_instr[3]), 64'(NOP));
    check("t4_i4", 64'(log_instr[4]), 64'h0F000A13);
    check("t4_pc4", log_pc[4], 64'd0);
    check("t4_pc5", log_pc[5], 64'd4);
    check("t4_pass", 64'(pass), 64'd1);
    stuck_pc = 1'b1;
    run_prog(cyc, rcyc);
    stuck_pc = 1'b0;
    check("t4s_fail_count", 64'(fail_count), 64'd2);
    check("t4s_fail_idx", 64'(fail_idx), 64'd1);
    check("t4s_pass", 64'(pass), 64'd0);

    // Fill beyond capacity.
    do_clear();
    acc = 0;
    load_valid = 1'b1; load_seg = 1'b0; load_chk = 1'b0; load_instr = NOP;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (load_ready) acc++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    check("t5_accepted", 64'(acc), 64'(DEPTH));
    check("t5_ready_full", 64'(load_ready), 64'd0);
    run_prog(cyc, rcyc);
    check("t5_cycles", 64'(cyc), 64'(DEPTH + 1));
    check("t5_pass", 64'(pass), 64'd1);

    // Empty program.
    do_clear();
    run_prog(cyc, rcyc);
    check("t6_cycles", 64'(cyc), 64'd0);
    check("t6_done", 64'(done), 64'd1);
    check("t6_pass", 64'(pass), 64'd1);

    // Reset during ISSUE of entry 1.
    do_clear();
    load_entry(1'b1, 32'h00500093, 1'b0, 5'd0, 64'd0);
    load_entry(1'b0, 32'h00600113, 1'b0, 5'd0, 64'd0);
    load_entry(1'b0, 32'h002081B3, 1'b1, 5'd3, 64'd11);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t7_issue1", 64'(instruction), 64'h00600113);
    rst = 1'b1;
    #1;
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_done", 64'(done), 64'd0);
    check("t7_instr", 64'(instruction), 64'(NOP));
    check("t7_dp_rst", 64'(dp_rst), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_prog(cyc, rcyc);
    check("t7_empty_cycles", 64'(cyc), 64'd0);
    check("t7_pass", 64'(pass), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dp_selftest_seq.md
# dp_selftest_seq

Synthesisable, parametrised self-test sequencer for the RV64I single-cycle `datapath`. It stores a small program of instruction entries, each with an optional register-writeback check. It drives the entries into the datapath one per cycle and pulses the datapath reset at segment boundaries. It checks the datapath's PC and writeback port against expected values and reports pass/fail counts, giving on-chip regression without a simulator.

## Interface
Parameters:
- XLEN, 64, datapath register/PC width.
- DEPTH, 16, program entries (>= 2); IW = $clog2(DEPTH), CW = $clog2(DEPTH+1).
- NOP, 32'h00000013, instruction driven when not issuing.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- load_valid  in  1  program entry offered.
- load_ready  out  1  entry accepted when valid & ready.
- load_instr  in  32  instruction word.
- load_seg  in  1  entry starts a new segment (datapath reset, expected PC restarts at 0).
- load_chk  in  1  check writeback for this entry.
- load_rd  in  5  expected destination register.
- load_exp  in  XLEN  expected writeback data.
- clear  in  1  discard program (IDLE/DONE only).
- start  in  1  run program (IDLE/DONE only).
- instruction  out  32  to datapath `instruction`.
- dp_rst  out  1  to datapath `rst`.
- pc_in  in  XLEN  datapath `pc_out`.
- wb_en, wb_rd, wb_data  in  1/5/XLEN  datapath register-file write port.
- busy  out  1  RST or ISSUE state.
- done  out  1  run complete; held until start/clear.
- pass  out  1  done & fail_count==0.
- fail_count  out  CW  entries that failed in the last run.
- fail_idx  out  IW  index of first failing entry (valid when fail_count!=0).

## Operation
- States: IDLE, RST, ISSUE, DONE. Async rst -> IDLE, wr_cnt=0, idx=0, pc_ref=0, fail_count=0, fail_idx=0, done=0, instruction=NOP. Memory contents are not reset.
- dp_rst = rst | (state==RST), combinational.
- Load: load_ready = (state==IDLE) & (wr_cnt<DEPTH). An accepted entry is written at wr_cnt, then wr_cnt++. At wr_cnt==DEPTH, load_ready=0 and further offers are not accepted.
- clear (IDLE/DONE): wr_cnt=0, fail_count=0, done=0, next state IDLE. clear has priority over start.
- start (IDLE/DONE): with wr_cnt==0 -> DONE, fail_count=0 (pass=1). Otherwise idx=0, fail_count=0, fail_idx=0 -> RST. Entry 0 is always treated as seg=1.
- start with an accepted load in the same IDLE cycle: the entry is stored and included in the run.
- start, clear and load are ignored while busy.
- RST (1 cycle): dp_rst=1, instruction=NOP, pc_ref<=0 -> ISSUE.
- ISSUE: instruction = mem[idx].instr. At the closing clock edge:
  - fail_e = (pc_in != pc_ref) | (chk & (!wb_en | wb_rd != rd | wb_data != exp)).
  - If fail_e: fail_count++. If fail_count was 0, fail_idx=idx.
  - pc_ref += 4, modulo 2^XLEN.
  - If idx==wr_cnt-1 -> DONE. Otherwise idx++, then RST if mem[idx+1].seg else ISSUE.
- Unchecked entries (chk=0) are checked for PC only; writeback is ignored.
- DONE: instruction=NOP, done=1. The program is retained and start reruns it.

## Timing
- One entry per cycle. Run length = entries + segments cycles from start-accept to DONE.
- Comparisons use pc_in/wb_* sampled at the rising edge ending each ISSUE cycle. The datapath is single-cycle, so the write for instruction k is visible in that same cycle.
- done rises the cycle after the last ISSUE edge. fail_count/fail_idx are final when done=1.
- rst mid-run: immediate IDLE, program discarded (wr_cnt=0), done=0, dp_rst=1 while rst is high.

## Test plan
- Load 1 entry {seg=1, 0x00C00293, chk, rd=5, exp=12}, start, model datapath -> 2 run cycles, dp_rst high 1 cycle, pc_in=0 in ISSUE, done=1, pass=1, fail_count=0.
- Load {seg 0x00500093}, {0x00600113}, {0x002081B3, chk rd=3 exp=11} -> instructions issued in order after 1 RST cycle, pc_ref 0/4/8 checked, pass=1.
- Same program with exp=13 on entry 2 -> fail_count=1, fail_idx=2, pass=0. Rerun with start -> identical result.
- Two segments: {seg 0x00F00313}, {0x00500393}, {seg 0x0F000A13}, {0x05500A93} -> dp_rst pulses before entries 0 and 2, pc_ref restarts at 0, 6 run cycles. Stuck pc_in=0 -> fail_count=2, fail_idx=1.
- Load DEPTH+2 offers -> exactly DEPTH accepted, load_ready=0 after. Start -> DEPTH+1 run cycles. start with empty program -> DONE next cycle, pass=1.
- Assert rst during ISSUE of entry 1 -> state IDLE, busy=0, done=0, wr_cnt=0, instruction=NOP. start afterwards -> immediate DONE, pass=1.
